// File: rtl/apb3_requester_pkg.sv
// apb3_requester_pkg: shared FSM state type and the per-beat address/data pattern helpers
// for the APB3 requester sequencer.
package apb3_requester_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb3_state_e;

    localparam logic [31:0] PatternXor = 32'hA5A5_0000;

    function automatic logic [31:0] beat_pattern(input logic [15:0] index, input logic [15:0] beat);
        return {index, beat} ^ PatternXor;
    endfunction

    // Byte address of a beat; wraps modulo 2^32 here, callers truncate to their bus width.
    function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [31:0] index,
                                              input logic [15:0] beat, input int b2b);
        return base + ((index * 32'(b2b) + 32'(beat)) << 2);
    endfunction

endpackage

// File: rtl/apb3_read_checker.sv
// apb3_read_checker: completion side of the requester; captures read beats, checks them
// against the beat pattern and keeps the saturating error count.
module apb3_read_checker
    import apb3_requester_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        beat_done,
    input  logic        is_read,
    input  logic        pslverr,
    input  logic        timeout_evt,
    input  logic [15:0] index_lo,
    input  logic [15:0] beat,
    input  logic [31:0] prdata,
    output logic        rdata_valid,
    output logic [31:0] rdata,
    output logic [15:0] error_count
);

    logic        rdata_valid_q, rdata_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] err_q, err_d;
    logic        mismatch, bump;

    // A slave error and a data mismatch on the same beat count as one event.
    always_comb begin
        mismatch      = is_read && (prdata != beat_pattern(index_lo, beat));
        bump          = timeout_evt || (beat_done && (pslverr || mismatch));
        rdata_valid_d = beat_done && is_read;
        rdata_d       = rdata_valid_d ? prdata : rdata_q;
        err_d         = (bump && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_valid_q <= 1'b0;
            rdata_q       <= '0;
            err_q         <= '0;
        end else begin
            rdata_valid_q <= rdata_valid_d;
            rdata_q       <= rdata_d;
            err_q         <= err_d;
        end
    end

    assign rdata_valid = rdata_valid_q;
    assign rdata       = rdata_q;
    assign error_count = err_q;

endmodule

// File: rtl/apb3_requester_sequencer.sv
// apb3_requester_sequencer: turns each start pulse into a burst of APB3 transfers with a fixed
// data pattern, and reports errors, timeouts and starts that arrive while busy.
module apb3_requester_sequencer
    import apb3_requester_pkg::*;
#(
    parameter int                      AddressWidth  = 20,
    parameter logic [AddressWidth-1:0] BaseAddress   = '0,
    parameter int                      Back2BackNum  = 2,
    parameter int                      TimeoutCycles = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    start_transaction,
    input  logic                    write_mode,
    input  logic [31:0]             index,
    output logic [AddressWidth-1:0] paddr,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [31:0]             pwdata,
    input  logic [31:0]             prdata,
    input  logic                    pready,
    input  logic                    pslverr,
    output logic                    busy,
    output logic                    rdata_valid,
    output logic [31:0]             rdata,
    output logic [15:0]             error_count,
    output logic                    timeout,
    output logic                    overrun
);

    localparam logic [15:0] LastBeat = 16'(Back2BackNum - 1);
    localparam logic [31:0] LastWait = 32'(TimeoutCycles - 1);

    apb3_state_e             state_q, state_d;
    logic [15:0]             beat_q, beat_d;
    logic [31:0]             wait_q, wait_d;
    logic [31:0]             idx_q, idx_d;
    logic                    wmode_q, wmode_d;
    logic [AddressWidth-1:0] paddr_q, paddr_d;
    logic [31:0]             pwdata_q, pwdata_d;
    logic                    pwrite_q, pwrite_d;
    logic                    timeout_q, timeout_d;
    logic                    overrun_q, overrun_d;
    logic                    beat_done, tmo_evt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            wait_q    <= '0;
            idx_q     <= '0;
            wmode_q   <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            wait_q    <= wait_d;
            idx_q     <= idx_d;
            wmode_q   <= wmode_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        wait_d    = wait_q;
        idx_d     = idx_q;
        wmode_d   = wmode_q;
        beat_done = 1'b0;
        tmo_evt   = 1'b0;
        unique case (state_q)
            IDLE: if (start_transaction) begin
                state_d = SETUP;
                beat_d  = '0;
                wait_d  = '0;
                idx_d   = index;
                wmode_d = write_mode;
            end
            SETUP: state_d = ACCESS;
            ACCESS: if (pready) begin
                beat_done = 1'b1;
                wait_d    = '0;
                state_d   = (beat_q < LastBeat) ? SETUP : IDLE;
                beat_d    = (beat_q < LastBeat) ? beat_q + 16'd1 : '0;
            end else if (wait_q == LastWait) begin
                tmo_evt = 1'b1;
                state_d = IDLE;
                beat_d  = '0;
                wait_d  = '0;
            end else begin
                wait_d = wait_q + 32'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus fields are computed from the next beat so they are already valid in SETUP.
    always_comb begin
        paddr_d   = (state_d != IDLE) ? AddressWidth'(beat_addr(32'(BaseAddress), idx_d, beat_d, Back2BackNum)) : '0;
        pwrite_d  = (state_d != IDLE) && wmode_d;
        pwdata_d  = pwrite_d ? beat_pattern(idx_d[15:0], beat_d) : '0;
        timeout_d = timeout_q | tmo_evt;
        overrun_d = overrun_q | (start_transaction && state_q != IDLE);
    end

    apb3_read_checker u_checker (
        .clk         (clk),
        .resetn      (resetn),
        .beat_done   (beat_done),
        .is_read     (!wmode_q),
        .pslverr     (pslverr),
        .timeout_evt (tmo_evt),
        .index_lo    (idx_q[15:0]),
        .beat        (beat_q),
        .prdata      (prdata),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .error_count (error_count)
    );

    assign paddr   = paddr_q;
    assign psel    = (state_q != IDLE);
    assign penable = (state_q == ACCESS);
    assign pwrite  = pwrite_q;
    assign pwdata  = pwdata_q;
    assign busy    = (state_q != IDLE);
    assign timeout = timeout_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_apb3_requester_sequencer.sv
// tb_apb3_requester_sequencer: directed scenarios for the APB3 requester sequencer with
// hand-computed addresses, data patterns, cycle counts and error counts.
module tb_apb3_requester_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start_transaction = 1'b0;
    logic        write_mode = 1'b0;
    logic [31:0] index = '0;
    logic [19:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata, prdata;
    logic        pready = 1'b1;
    logic        pslverr = 1'b0;
    logic        busy, rdata_valid, timeout, overrun;
    logic [31:0] rdata;
    logic [15:0] error_count;

    logic [31:0] mem [16];
    logic [31:0] aq[$], wq[$], rq[$];
    int psel_n, acc_n, busy_n;
    int err = 0;
    int chk = 0;

    always #5 clk = ~clk;

    assign prdata = mem[paddr[5:2]];

    apb3_requester_sequencer dut (
        .clk(clk), .resetn(resetn), .start_transaction(start_transaction),
        .write_mode(write_mode), .index(index), .paddr(paddr), .psel(psel),
        .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .busy(busy), .rdata_valid(rdata_valid),
        .rdata(rdata), .error_count(error_count), .timeout(timeout), .overrun(overrun)
    );

    always @(negedge clk) begin
        if (psel && !penable) begin
            aq.push_back(32'(paddr));
            wq.push_back(pwdata);
        end
        if (rdata_valid) rq.push_back(rdata);
        if (psel) psel_n++;
        if (penable) acc_n++;
        if (busy) busy_n++;
    end

    task automatic clr();
        aq.delete(); wq.delete(); rq.delete();
        psel_n = 0; acc_n = 0; busy_n = 0;
    endtask

    task automatic do_reset();
        resetn = 1'b0; start_transaction = 1'b0; pready = 1'b1; pslverr = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        clr();
    endtask

    task automatic do_start(input logic wr, input logic [31:0] idx);
        @(negedge clk);
        start_transaction = 1'b1; write_mode = wr; index = idx;
        @(negedge clk);
        start_transaction = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #3;
        chk++;
        if ({paddr, psel, penable, pwrite, pwdata, busy, rdata_valid, rdata, error_count, timeout, overrun} !== '0) begin
            err++; $display("FAIL reset_low outputs nonzero psel=%b paddr=%h ec=%0d", psel, paddr, error_count);
        end
        do_reset();
        chk++;
        if ({paddr, psel, penable, pwrite, pwdata, busy, rdata_valid, rdata, error_count, timeout, overrun} !== '0) begin
            err++; $display("FAIL reset_release outputs nonzero psel=%b paddr=%h ec=%0d", psel, paddr, error_count);
        end
    endtask

    task automatic test_write();
        do_reset();
        do_start(1'b1, 32'd3);
        repeat (6) @(negedge clk);
        chk++;
        if (aq.size() != 2 || aq[0] !== 32'h18 || aq[1] !== 32'h1C) begin
            err++; $display("FAIL wr_addr got=%p exp=18,1c", aq);
        end
        chk++;
        if (wq.size() != 2 || wq[0] !== 32'hA5A6_0000 || wq[1] !== 32'hA5A6_0001) begin
            err++; $display("FAIL wr_data got=%p exp=a5a60000,a5a60001", wq);
        end
        chk++;
        if (psel_n !== 4) begin err++; $display("FAIL wr_psel_cycles got=%0d exp=4", psel_n); end
        chk++;
        if (error_count !== 16'd0 || busy !== 1'b0 || paddr !== 20'h0 || pwdata !== 32'h0 || pwrite !== 1'b0) begin
            err++; $display("FAIL wr_end ec=%0d busy=%b paddr=%h pwdata=%h pwrite=%b exp 0", error_count, busy, paddr, pwdata, pwrite);
        end
    endtask

    task automatic test_read();
        do_reset();
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[6] = 32'hA5A6_0000;
        mem[7] = 32'hA5A6_0001;
        do_start(1'b0, 32'd3);
        repeat (6) @(negedge clk);
        chk++;
        if (rq.size() != 2 || rq[0] !== 32'hA5A6_0000 || rq[1] !== 32'hA5A6_0001) begin
            err++; $display("FAIL rd_data got=%p exp=a5a60000,a5a60001", rq);
        end
        chk++;
        if (wq.size() != 2 || wq[0] !== 32'h0 || wq[1] !== 32'h0) begin
            err++; $display("FAIL rd_pwdata got=%p exp=0,0", wq);
        end
        chk++;
        if (error_count !== 16'd0) begin err++; $display("FAIL rd_clean_ec got=%0d exp=0", error_count); end
        mem[7] = 32'hA5A6_0000;
        clr();
        do_start(1'b0, 32'd3);
        repeat (6) @(negedge clk);
        chk++;
        if (error_count !== 16'd1) begin err++; $display("FAIL rd_corrupt_ec got=%0d exp=1", error_count); end
        chk++;
        if (rq.size() != 2 || rq[1] !== 32'hA5A6_0000) begin
            err++; $display("FAIL rd_corrupt_data got=%p exp=a5a60000,a5a60000", rq);
        end
    endtask

    task automatic test_wait_states();
        int held = 0;
        do_reset();
        pready = 1'b0;
        do_start(1'b1, 32'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (penable === 1'b1 && paddr === 20'h18 && pwdata === 32'hA5A6_0000) held++;
            if (i == 3) pready = 1'b1;
        end
        repeat (4) @(negedge clk);
        chk++;
        if (held !== 4) begin err++; $display("FAIL wait_hold got=%0d exp=4", held); end
        chk++;
        if (busy_n !== 7) begin err++; $display("FAIL wait_busy got=%0d exp=7", busy_n); end
        chk++;
        if (aq.size() != 2 || aq[1] !== 32'h1C) begin err++; $display("FAIL wait_addr got=%p exp=18,1c", aq); end
    endtask

    task automatic test_timeout();
        do_reset();
        pready = 1'b0;
        do_start(1'b1, 32'd3);
        repeat (20) @(negedge clk);
        chk++;
        if (acc_n !== 16) begin err++; $display("FAIL tmo_access got=%0d exp=16", acc_n); end
        chk++;
        if (timeout !== 1'b1 || error_count !== 16'd1 || psel !== 1'b0) begin
            err++; $display("FAIL tmo_flags timeout=%b ec=%0d psel=%b exp 1,1,0", timeout, error_count, psel);
        end
        chk++;
        if (aq.size() != 1) begin err++; $display("FAIL tmo_beats got=%p exp=18", aq); end
        pready = 1'b1;
    endtask

    task automatic test_overrun_and_reset();
        do_reset();
        do_start(1'b1, 32'd5);
        start_transaction = 1'b1; write_mode = 1'b0; index = 32'd9;
        @(negedge clk);
        start_transaction = 1'b0;
        repeat (5) @(negedge clk);
        chk++;
        if (overrun !== 1'b1) begin err++; $display("FAIL ovr_setup got=%b exp=1", overrun); end
        chk++;
        if (aq.size() != 2 || aq[0] !== 32'h28 || aq[1] !== 32'h2C || wq[0] !== 32'hA5A0_0000 || wq[1] !== 32'hA5A0_0001) begin
            err++; $display("FAIL ovr_burst addr=%p data=%p exp=28,2c a5a00000,a5a00001", aq, wq);
        end
        do_reset();
        do_start(1'b1, 32'd3);
        repeat (2) @(negedge clk);
        start_transaction = 1'b1;
        @(negedge clk);
        start_transaction = 1'b0;
        repeat (3) @(negedge clk);
        chk++;
        if (overrun !== 1'b1 || psel_n !== 4 || busy !== 1'b0) begin
            err++; $display("FAIL ovr_final overrun=%b psel_n=%0d busy=%b exp 1,4,0", overrun, psel_n, busy);
        end
        pready = 1'b0;
        do_start(1'b1, 32'd3);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk++;
        if ({paddr, psel, penable, pwrite, pwdata, busy, rdata_valid, rdata, error_count, timeout, overrun} !== '0) begin
            err++; $display("FAIL async_reset psel=%b penable=%b paddr=%h overrun=%b exp 0", psel, penable, paddr, overrun);
        end
        @(negedge clk);
        resetn = 1'b1;
        pready = 1'b1;
    endtask

    task automatic test_pslverr();
        do_reset();
        pslverr = 1'b1;
        do_start(1'b1, 32'd1);
        @(negedge clk);
        @(negedge clk);
        pslverr = 1'b0;
        repeat (4) @(negedge clk);
        chk++;
        if (error_count !== 16'd1) begin err++; $display("FAIL slverr_ec got=%0d exp=1", error_count); end
        chk++;
        if (psel_n !== 4 || aq.size() != 2 || aq[0] !== 32'h08 || aq[1] !== 32'h0C || wq[0] !== 32'hA5A4_0000) begin
            err++; $display("FAIL slverr_burst psel_n=%0d addr=%p data=%p exp 4 08,0c a5a40000", psel_n, aq, wq);
        end
        mem[6] = 32'hA5A6_0002;
        mem[7] = 32'hA5A6_0001;
        clr();
        pslverr = 1'b1;
        do_start(1'b0, 32'd3);
        @(negedge clk);
        @(negedge clk);
        pslverr = 1'b0;
        repeat (4) @(negedge clk);
        chk++;
        if (error_count !== 16'd2) begin err++; $display("FAIL slverr_mismatch_once got=%0d exp=2", error_count); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset();
        test_write();
        test_read();
        test_wait_states();
        test_timeout();
        test_overrun_and_reset();
        test_pslverr();
        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end

endmodule
